// File: rtl/irig_pwm_symdec.sv
// irig_pwm_symdec
//   Decodes an IRIG-B DC-level (pulse-width modulated) time code into
//   symbols (data 0, data 1, position marker) and tracks frame alignment.
//   Each symbol is classified from the length of its high pulse, measured
//   in carrier cycles. Two consecutive markers establish frame lock.
//   While locked, each symbol must match the marker/data layout of a frame.
//
// Parameters
//   CYC_PER_MS  carrier cycles per millisecond (4..25)
//   TOUT_MS     symbol-gap timeout in milliseconds
//
// Ports
//   carrier      in   sole clock, rising edge
//   reset        in   synchronous, active-low
//   irig_in      in   asynchronous PWM time code
//   sym_valid    out  one-cycle strobe, classified symbol
//   sym_bit      out  data value (with sym_valid)
//   sym_marker   out  position marker (with sym_valid)
//   sym_err      out  one-cycle strobe, malformed pulse or gap timeout
//   locked       out  frame alignment achieved
//   frame_start  out  strobe with sym_valid of the symbol at index 0
//   bit_idx      out  frame position 0..99 (0 when not locked)
module irig_pwm_symdec #(
    parameter int CYC_PER_MS = 10,
    parameter int TOUT_MS    = 12
) (
    input  logic       carrier,
    input  logic       reset,
    input  logic       irig_in,
    output logic       sym_valid,
    output logic       sym_bit,
    output logic       sym_marker,
    output logic       sym_err,
    output logic       locked,
    output logic       frame_start,
    output logic [6:0] bit_idx
);

    // Pulse-width thresholds (truncated 1, 3.5, 6.5, 9.5 ms)
    localparam logic [7:0]  T_ERR   = 8'(CYC_PER_MS);
    localparam logic [7:0]  T_B0    = 8'((7 * CYC_PER_MS) / 2);
    localparam logic [7:0]  T_B1    = 8'((13 * CYC_PER_MS) / 2);
    localparam logic [7:0]  T_MK    = 8'((19 * CYC_PER_MS) / 2);
    localparam logic [7:0]  H_OVR   = T_MK + 8'd1;
    localparam logic [15:0] GAP_LIM = 16'(TOUT_MS * CYC_PER_MS);
    localparam logic [15:0] GAP_PRE = GAP_LIM - 16'd1;

    typedef enum logic [1:0] {
        HUNT,
        GOT_M1,
        LOCKED
    } frame_state_t;

    frame_state_t state, state_nxt;

    logic        sync1, irig_s, irig_d;
    logic [1:0]  sync_ok;
    logic        armed, pulse_ok;
    logic [7:0]  h_cnt;
    logic [15:0] gap_cnt;

    logic        rise, fall, ov_err, gap_err;
    logic        ev_sym, ev_bit, ev_mk, ev_err;
    logic [6:0]  idx_nxt, exp_idx;
    logic        fs_nxt;

    function automatic logic is_marker_pos(input logic [6:0] i);
        case (i)
            7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
            7'd59, 7'd69, 7'd79, 7'd89, 7'd99: is_marker_pos = 1'b1;
            default:                           is_marker_pos = 1'b0;
        endcase
    endfunction

    assign rise = irig_s & ~irig_d;
    assign fall = ~irig_s & irig_d;

    // Overrun fires once when H steps past the marker limit; the rise cycle
    // is excluded because H still holds the previous pulse's width there.
    assign ov_err  = irig_s & ~rise & pulse_ok & (h_cnt == H_OVR);
    assign gap_err = ~irig_s & (gap_cnt == GAP_PRE);

    // Symbol classification, errors take precedence over an edge
    always_comb begin
        ev_sym = 1'b0;
        ev_bit = 1'b0;
        ev_mk  = 1'b0;
        ev_err = 1'b0;
        if (ov_err || gap_err) begin
            ev_err = 1'b1;
        end else if (fall && pulse_ok) begin
            if (h_cnt < T_ERR) begin
                ev_err = 1'b1;
            end else if (h_cnt <= T_B0) begin
                ev_sym = 1'b1;
            end else if (h_cnt <= T_B1) begin
                ev_sym = 1'b1;
                ev_bit = 1'b1;
            end else if (h_cnt <= T_MK) begin
                ev_sym = 1'b1;
                ev_mk  = 1'b1;
            end else if (h_cnt == H_OVR) begin
                // Fell exactly as H reached the overrun value, so the
                // overrun strobe never fired; longer pulses were reported.
                ev_err = 1'b1;
            end
        end
    end

    // Frame tracking, evaluated on the same event that is being registered
    // so locked/bit_idx change together with sym_valid/sym_err.
    always_comb begin
        state_nxt = state;
        idx_nxt   = bit_idx;
        fs_nxt    = 1'b0;
        exp_idx   = (bit_idx == 7'd99) ? 7'd0 : bit_idx + 7'd1;
        case (state)
            HUNT: begin
                idx_nxt = '0;
                if (ev_mk) state_nxt = GOT_M1;
            end
            GOT_M1: begin
                idx_nxt = '0;
                if (ev_mk) begin
                    state_nxt = LOCKED;
                    fs_nxt    = 1'b1;
                end else if (ev_sym || ev_err) begin
                    state_nxt = HUNT;
                end
            end
            LOCKED: begin
                if (ev_err) begin
                    state_nxt = HUNT;
                    idx_nxt   = '0;
                end else if (ev_sym) begin
                    if (ev_mk == is_marker_pos(exp_idx)) begin
                        idx_nxt = exp_idx;
                        fs_nxt  = (exp_idx == 7'd0);
                    end else begin
                        // A misplaced marker may itself open a new frame
                        state_nxt = ev_mk ? GOT_M1 : HUNT;
                        idx_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge carrier) begin
        if (!reset) begin
            sync1       <= 1'b0;
            irig_s      <= 1'b0;
            irig_d      <= 1'b0;
            sync_ok     <= '0;
            armed       <= 1'b0;
            pulse_ok    <= 1'b0;
            h_cnt       <= '0;
            gap_cnt     <= '0;
            state       <= HUNT;
            bit_idx     <= '0;
            sym_valid   <= 1'b0;
            sym_bit     <= 1'b0;
            sym_marker  <= 1'b0;
            sym_err     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sync1   <= irig_in;
            irig_s  <= sync1;
            irig_d  <= irig_s;
            sync_ok <= {sync_ok[0], 1'b1};

            // After reset the synchronizer refills from zero, which looks
            // like a rise mid-pulse; only a genuinely observed low arms
            // classification of the following pulse.
            if (sync_ok[1] && !irig_s) armed <= 1'b1;
            if (rise)      pulse_ok <= armed;
            else if (fall) pulse_ok <= 1'b0;

            if (rise)                         h_cnt <= 8'd1;
            else if (irig_s && h_cnt != '1)   h_cnt <= h_cnt + 8'd1;

            if (rise)                            gap_cnt <= '0;
            else if (!irig_s && gap_cnt != GAP_LIM) gap_cnt <= gap_cnt + 16'd1;

            state       <= state_nxt;
            bit_idx     <= idx_nxt;
            sym_valid   <= ev_sym;
            sym_bit     <= ev_bit;
            sym_marker  <= ev_mk;
            sym_err     <= ev_err;
            frame_start <= fs_nxt;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_irig_pwm_symdec.sv
// tb_irig_pwm_symdec
//   Self-checking bench for irig_pwm_symdec (CYC_PER_MS=10, TOUT_MS=12).
//   Pulses are described by high/low lengths; a pulse-level reference model
//   predicts each symbol/error event, its cycle, and the frame state after it.
module tb_irig_pwm_symdec;

    localparam int M    = 10;
    localparam int TOUT = 12;

    logic       carrier = 1'b0;
    logic       reset   = 1'b0;
    logic       irig_in = 1'b0;
    logic       sym_valid, sym_bit, sym_marker, sym_err, locked, frame_start;
    logic [6:0] bit_idx;

    irig_pwm_symdec #(.CYC_PER_MS(M), .TOUT_MS(TOUT)) dut (
        .carrier    (carrier),
        .reset      (reset),
        .irig_in    (irig_in),
        .sym_valid  (sym_valid),
        .sym_bit    (sym_bit),
        .sym_marker (sym_marker),
        .sym_err    (sym_err),
        .locked     (locked),
        .frame_start(frame_start),
        .bit_idx    (bit_idx)
    );

    always #5 carrier = ~carrier;

    typedef struct {
        int t;
        bit err;
        bit b;
        bit mk;
        bit fs;
        bit lk;
        int idx;
    } ev_t;

    ev_t evq[$];

    int cyc     = 0;
    int n_vec   = 0;
    int n_err   = 0;
    int m_state = 0;     // 0 hunting, 1 one marker seen, 2 locked
    int m_idx   = 0;
    bit cur_lk  = 0;
    int cur_idx = 0;

    // Width limits in cycles: 3.5, 6.5 and 9.5 ms truncated
    int b0_max  = (35 * M) / 10;
    int b1_max  = (65 * M) / 10;
    int mk_max  = (95 * M) / 10;
    int gap_lim = TOUT * M;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic bit mark_pos(input int i);
        return (i == 0) || (i % 10 == 9);
    endfunction

    // kind: 0 error, 1 data 0, 2 data 1, 3 marker
    function automatic void push_ev(input int t, input int kind);
        ev_t e;
        int  nxt;
        e.t   = t;
        e.err = (kind == 0);
        e.b   = (kind == 2);
        e.mk  = (kind == 3);
        e.fs  = 0;
        if (m_state == 2) begin
            nxt = (m_idx + 1) % 100;
            if (kind != 0 && ((kind == 3) == mark_pos(nxt))) begin
                m_idx = nxt;
                e.fs  = (nxt == 0);
            end else begin
                m_state = (kind == 3) ? 1 : 0;
                m_idx   = 0;
            end
        end else if (m_state == 1) begin
            if (kind == 3) begin
                m_state = 2;
                m_idx   = 0;
                e.fs    = 1;
            end else begin
                m_state = 0;
            end
        end else begin
            m_state = (kind == 3) ? 1 : 0;
        end
        e.lk  = (m_state == 2);
        e.idx = m_idx;
        evq.push_back(e);
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_idx   = 0;
        cur_lk  = 0;
        cur_idx = 0;
        evq.delete();
    endfunction

    // Called at a negedge. irig_in is first sampled high at posedge t_r and
    // first sampled low at t_f = t_r + h; outputs follow 2 cycles later.
    task automatic send_pulse(input int h, input int l);
        int t_r, t_f;
        t_r = cyc + 1;
        t_f = t_r + h;
        if (h > mk_max + 1)
            push_ev(t_r + mk_max + 3, 0);
        else if (h < M || h == mk_max + 1)
            push_ev(t_f + 2, 0);
        else if (h <= b0_max)
            push_ev(t_f + 2, 1);
        else if (h <= b1_max)
            push_ev(t_f + 2, 2);
        else
            push_ev(t_f + 2, 3);
        if (l >= gap_lim)
            push_ev(t_f + gap_lim + 1, 0);
        irig_in = 1'b1;
        repeat (h) @(negedge carrier);
        irig_in = 1'b0;
        repeat (l) @(negedge carrier);
    endtask

    function automatic int rand_h(input int kind);
        if (kind == 1) return int'($urandom_range(M, b0_max));
        if (kind == 2) return int'($urandom_range(b0_max + 1, b1_max));
        return int'($urandom_range(b1_max + 1, mk_max));
    endfunction

    task automatic send_sym(input int kind, input int l);
        send_pulse(rand_h(kind), l);
    endtask

    function automatic int kind_at(input int i);
        if (mark_pos(i)) return 3;
        return 1 + int'($urandom_range(0, 1));
    endfunction

    task automatic send_frame(input int from_i, input int to_i);
        for (int i = from_i; i <= to_i; i++)
            send_sym(kind_at(i), int'($urandom_range(8, 30)));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        @(negedge carrier);
        reset = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model
    always @(posedge carrier) begin
        logic [31:0] obs, want;
        ev_t e;
        cyc++;
        #1;
        while (evq.size() > 0 && evq[0].t < cyc) begin
            check_eq("event_time", 32'(cyc), 32'(evq[0].t));
            e       = evq.pop_front();
            cur_lk  = e.lk;
            cur_idx = e.idx;
        end
        obs = {19'd0, sym_valid, sym_err, sym_bit, sym_marker, frame_start, locked, bit_idx};
        if (evq.size() > 0 && evq[0].t == cyc) begin
            e       = evq.pop_front();
            cur_lk  = e.lk;
            cur_idx = e.idx;
            want = {19'd0, !e.err, e.err, e.b, e.mk, e.fs, e.lk, 7'(e.idx)};
            check_eq(e.err ? "err_event" : "sym_event", obs, want);
        end else begin
            want = {19'd0, 5'b0, cur_lk, 7'(cur_idx)};
            check_eq("idle", obs, want);
        end
    end

    initial begin
        repeat (3) @(negedge carrier);
        reset = 1'b1;
        repeat (10) @(negedge carrier);

        // Nominal widths: data 0, data 1, marker
        send_pulse(20, 80);
        send_pulse(50, 50);
        send_pulse(80, 20);
        // Runt pulse, then a stuck-high pulse
        send_pulse(5, 95);
        send_pulse(200, 30);

        // Classification boundaries
        send_pulse(1, 20);
        send_pulse(9, 20);
        send_pulse(10, 20);
        send_pulse(35, 20);
        send_pulse(36, 20);
        send_pulse(65, 20);
        send_pulse(66, 20);
        send_pulse(95, 20);
        send_pulse(96, 20);
        send_pulse(97, 20);

        // Lock on two markers, full frame, wrap, then data bit at index 29
        send_sym(3, 20);
        send_sym(3, 20);
        send_frame(1, 99);
        send_frame(0, 28);
        send_sym(1 + int'($urandom_range(0, 1)), 20);
        send_frame(30, 33);

        // Gap timeout while locked
        send_sym(3, 20);
        send_sym(3, 20);
        send_frame(1, 5);
        send_sym(kind_at(6), 130);
        send_frame(7, 9);

        // Reset at index 57, relock requires two fresh markers
        send_sym(3, 20);
        send_sym(3, 20);
        send_frame(1, 57);
        pulse_reset();
        repeat (5) @(negedge carrier);
        send_sym(3, 20);
        send_sym(3, 20);
        send_frame(1, 3);

        // Reset in the middle of a pulse: its falling edge is ignored
        irig_in = 1'b1;
        repeat (30) @(negedge carrier);
        pulse_reset();
        repeat (50) @(negedge carrier);
        irig_in = 1'b0;
        repeat (20) @(negedge carrier);
        send_sym(3, 20);
        send_sym(3, 20);
        send_frame(1, 2);

        // Randomized: partial frames with random corruption, then free pulses
        for (int r = 0; r < 4; r++) begin
            send_sym(3, int'($urandom_range(5, 40)));
            send_sym(3, int'($urandom_range(5, 40)));
            send_frame(1, int'($urandom_range(5, 40)));
            for (int k = 0; k < 4; k++)
                send_pulse(int'($urandom_range(1, 110)), int'($urandom_range(3, 60)));
        end
        for (int k = 0; k < 80; k++)
            send_pulse(int'($urandom_range(1, 110)), int'($urandom_range(3, 60)));

        repeat (10) @(negedge carrier);
        check_eq("pending_events", 32'(evq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
